// File: rtl/cache_tag_array_pkg.sv
// cache_tag_array_pkg: shared cache constants, default tag-array geometry and the sweep FSM state type
package cache_tag_array_pkg;
  localparam int DEF_WAYS = 4;
  localparam int DEF_SETS = 256;
  localparam int DEF_TAG_LEN = 20;
  localparam int DEF_LOG_W = $clog2(DEF_WAYS);
  localparam int DEF_LOG_H = $clog2(DEF_SETS);
  typedef enum logic {SWEEP, IDLE} state_t;
endpackage

// File: rtl/cache_tag_bank.sv
// cache_tag_bank: one way's tag+valid storage; registered read (rd_*), fill (wr_*, sets valid, wins over clr), valid clear (clr_*)
module cache_tag_bank
  import cache_tag_array_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int TAG_LEN = DEF_TAG_LEN,
  localparam int LOG_H = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic [LOG_H-1:0]   rd_index,
  output logic [TAG_LEN-1:0] rd_tag,
  output logic               rd_vbit,
  input  logic               wr_en,
  input  logic [LOG_H-1:0]   wr_index,
  input  logic [TAG_LEN-1:0] wr_tag,
  input  logic               clr_en,
  input  logic [LOG_H-1:0]   clr_index
);
  logic [TAG_LEN-1:0] tags [SETS];
  logic [SETS-1:0] vbits;
  always_ff @(posedge clk)
    if (wr_en) tags[wr_index] <= wr_tag;
  always_ff @(posedge clk) begin
    if (clr_en) vbits[clr_index] <= 1'b0;
    if (wr_en) vbits[wr_index] <= 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      rd_tag <= '0;
      rd_vbit <= 1'b0;
    end else if (rd_en) begin
      rd_tag <= tags[rd_index];
      rd_vbit <= vbits[rd_index];
    end
endmodule

// File: rtl/cache_tag_array.sv
// cache_tag_array: set-associative tag array; lk_* lookup -> rsp_* one cycle later, wr_* fill, inv_* invalidate, flush/busy valid sweep
module cache_tag_array
  import cache_tag_array_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS,
  parameter int TAG_LEN = DEF_TAG_LEN,
  localparam int LOG_W = $clog2(WAYS),
  localparam int LOG_H = $clog2(SETS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lk_valid,
  output logic                    lk_ready,
  input  logic [LOG_H-1:0]        lk_index,
  input  logic [TAG_LEN-1:0]      lk_tag,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic [LOG_W-1:0]        rsp_way,
  output logic [LOG_W-1:0]        rsp_victim,
  output logic [WAYS*TAG_LEN-1:0] rsp_tags,
  output logic [WAYS-1:0]         rsp_vbits,
  input  logic                    wr_en,
  input  logic [LOG_H-1:0]        wr_index,
  input  logic [LOG_W-1:0]        wr_way,
  input  logic [TAG_LEN-1:0]      wr_tag,
  input  logic                    inv_en,
  input  logic [LOG_H-1:0]        inv_index,
  input  logic [LOG_W-1:0]        inv_way,
  input  logic                    flush,
  output logic                    busy
);
  state_t state, state_n;
  logic [LOG_H-1:0] cnt, cnt_n;
  logic [LOG_W-1:0] ptr [SETS];
  logic [LOG_W-1:0] ptr_q;
  logic [TAG_LEN-1:0] tag_q;
  logic accept, wr_ok, inv_ok;
  assign busy = state == SWEEP;
  assign lk_ready = !busy;
  assign accept = lk_valid && lk_ready;
  assign wr_ok = wr_en && !busy && !flush && !reset;
  assign inv_ok = inv_en && !busy && !flush && !reset;
  always_ff @(posedge clk)
    if (reset) begin
      state <= SWEEP;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == SWEEP) begin
      cnt_n = flush ? '0 : cnt + 1'b1;
      state_n = (!flush && cnt == LOG_H'(SETS - 1)) ? IDLE : SWEEP;
    end else if (flush) begin
      state_n = SWEEP;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      rsp_valid <= 1'b0;
      tag_q <= '0;
      ptr_q <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        tag_q <= lk_tag;
        ptr_q <= ptr[lk_index];
      end
    end
  always_ff @(posedge clk)
    if (busy) ptr[cnt] <= '0;
    else if (wr_ok && wr_way == ptr[wr_index]) ptr[wr_index] <= ptr[wr_index] + 1'b1;
  for (genvar w = 0; w < WAYS; w++) begin : g_bank
    cache_tag_bank #(.SETS(SETS), .TAG_LEN(TAG_LEN)) u_bank (
      .clk(clk),
      .reset(reset),
      .rd_en(accept),
      .rd_index(lk_index),
      .rd_tag(rsp_tags[w*TAG_LEN +: TAG_LEN]),
      .rd_vbit(rsp_vbits[w]),
      .wr_en(wr_ok && wr_way == LOG_W'(w)),
      .wr_index(wr_index),
      .wr_tag(wr_tag),
      .clr_en(busy || (inv_ok && inv_way == LOG_W'(w))),
      .clr_index(busy ? cnt : inv_index)
    );
  end
  // descending scan so the lowest-index hit / invalid way is the one left standing
  always_comb begin
    rsp_hit = 1'b0;
    rsp_way = '0;
    rsp_victim = ptr_q;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (rsp_vbits[i] && rsp_tags[i*TAG_LEN +: TAG_LEN] == tag_q) begin
        rsp_hit = 1'b1;
        rsp_way = LOG_W'(i);
      end
      if (!rsp_vbits[i]) rsp_victim = LOG_W'(i);
    end
  end
endmodule

// File: tb/tb_cache_tag_array.sv
// tb_cache_tag_array: table-driven lookup/fill/invalidate vectors with a response scoreboard, plus flush and reset sequences
module tb_cache_tag_array;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lk_valid = 1'b0, lk_ready;
  logic [7:0] lk_index = '0;
  logic [19:0] lk_tag = '0;
  logic rsp_valid, rsp_hit;
  logic [1:0] rsp_way, rsp_victim;
  logic [79:0] rsp_tags;
  logic [3:0] rsp_vbits;
  logic wr_en = 1'b0;
  logic [7:0] wr_index = '0;
  logic [1:0] wr_way = '0;
  logic [19:0] wr_tag = '0;
  logic inv_en = 1'b0;
  logic [7:0] inv_index = '0;
  logic [1:0] inv_way = '0;
  logic flush = 1'b0, busy;
  int checks = 0, failures = 0, cyc = 0, nm = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  cache_tag_array dut (
    .clk(clk), .reset(reset),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_victim(rsp_victim),
    .rsp_tags(rsp_tags), .rsp_vbits(rsp_vbits),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_tag(wr_tag),
    .inv_en(inv_en), .inv_index(inv_index), .inv_way(inv_way),
    .flush(flush), .busy(busy)
  );
  typedef enum int {LK, WR, INV, WRINV, LKWR, LKINV} op_t;
  typedef struct {
    op_t op; logic [7:0] idx; logic [1:0] way; logic [19:0] tag;
    logic hit; logic [1:0] rway; logic [1:0] vic; logic [3:0] vb;
  } vec_t;
  typedef struct {
    logic hit; logic [1:0] way; logic [1:0] vic; logic [3:0] vb; logic [19:0] tag; int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  function automatic vec_t mk(op_t op, int idx, int way, int tag, bit hit = 0, int rway = 0, int vic = 0, int vb = 0);
    vec_t v;
    v.op = op; v.idx = 8'(idx); v.way = 2'(way); v.tag = 20'(tag);
    v.hit = hit; v.rway = 2'(rway); v.vic = 2'(vic); v.vb = 4'(vb);
    return v;
  endfunction
  always @(negedge clk)
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
      else begin
        e = q.pop_front();
        chk("rsp_latency", cyc, e.cyc + 1);
        chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
        chk("rsp_way", 32'(rsp_way), 32'(e.way));
        chk("rsp_victim", 32'(rsp_victim), 32'(e.vic));
        chk("rsp_vbits", 32'(rsp_vbits), 32'(e.vb));
        if (e.hit) chk("rsp_tag", 32'(rsp_tags[e.way*20 +: 20]), 32'(e.tag));
        nm = 0;
        for (int w = 0; w < 4; w++) if (rsp_vbits[w] && rsp_tags[w*20 +: 20] == e.tag) nm++;
        chk("match_count", nm, 32'(e.hit));
      end
    end
  task automatic apply(input vec_t x);
    lk_valid = x.op inside {LK, LKWR, LKINV};
    lk_index = x.idx; lk_tag = x.tag;
    wr_en = x.op inside {WR, WRINV, LKWR};
    wr_index = x.idx; wr_way = x.way; wr_tag = x.tag;
    inv_en = x.op inside {INV, WRINV, LKINV};
    inv_index = x.idx; inv_way = x.way;
    if (lk_valid) begin
      chk("lk_ready", 32'(lk_ready), 1);
      q.push_back('{hit: x.hit, way: x.rway, vic: x.vic, vb: x.vb, tag: x.tag, cyc: cyc});
    end
    @(posedge clk);
    #1;
    lk_valid = 1'b0; wr_en = 1'b0; inv_en = 1'b0;
  endtask
  task automatic wait_idle(input string name, input int base, input int expn);
    int n = base, bad = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      bad += int'(lk_ready == busy);
      n++;
      @(negedge clk);
    end
    chk(name, n, expn);
    chk({name, "_ready"}, bad, 0);
  endtask
  task automatic check_reset_outputs(input string name);
    chk({name, "_valid"}, 32'(rsp_valid), 0);
    chk({name, "_hit"}, 32'(rsp_hit), 0);
    chk({name, "_way"}, 32'(rsp_way), 0);
    chk({name, "_victim"}, 32'(rsp_victim), 0);
    chk({name, "_vbits"}, 32'(rsp_vbits), 0);
    chk({name, "_tags_zero"}, 32'(rsp_tags == 80'd0), 1);
    chk({name, "_busy"}, 32'(busy), 1);
    chk({name, "_ready"}, 32'(lk_ready), 0);
  endtask
  initial begin
    int n;
    tbl.push_back(mk(LK, 5, 0, 'h33, 0, 0, 0, 'b0000));
    tbl.push_back(mk(WR, 5, 0, 'h11));
    tbl.push_back(mk(WR, 5, 1, 'h22));
    tbl.push_back(mk(WR, 5, 2, 'h33));
    tbl.push_back(mk(WR, 5, 3, 'h44));
    tbl.push_back(mk(LK, 5, 0, 'h33, 1, 2, 0, 'b1111));
    tbl.push_back(mk(LK, 5, 0, 'h44, 1, 3, 0, 'b1111));
    tbl.push_back(mk(LK, 5, 0, 'h99, 0, 0, 0, 'b1111));
    tbl.push_back(mk(WR, 5, 0, 'h11));
    tbl.push_back(mk(LK, 5, 0, 'h11, 1, 0, 1, 'b1111));
    tbl.push_back(mk(WR, 5, 1, 'h22));
    tbl.push_back(mk(LK, 5, 0, 'h22, 1, 1, 2, 'b1111));
    tbl.push_back(mk(WR, 5, 2, 'h33));
    tbl.push_back(mk(LK, 5, 0, 'h33, 1, 2, 3, 'b1111));
    tbl.push_back(mk(WR, 5, 3, 'h44));
    tbl.push_back(mk(LK, 5, 0, 'h44, 1, 3, 0, 'b1111));
    tbl.push_back(mk(WR, 5, 2, 'h66));
    tbl.push_back(mk(LK, 5, 0, 'h66, 1, 2, 0, 'b1111));
    tbl.push_back(mk(LK, 5, 0, 'h33, 0, 0, 0, 'b1111));
    tbl.push_back(mk(INV, 5, 1, 0));
    tbl.push_back(mk(LK, 5, 0, 'h22, 0, 0, 1, 'b1101));
    tbl.push_back(mk(WRINV, 5, 1, 'h22));
    tbl.push_back(mk(LK, 5, 0, 'h22, 1, 1, 0, 'b1111));
    tbl.push_back(mk(LKINV, 5, 0, 'h11, 1, 0, 0, 'b1111));
    tbl.push_back(mk(LK, 5, 0, 'h11, 0, 0, 0, 'b1110));
    tbl.push_back(mk(LKWR, 7, 0, 'h55, 0, 0, 0, 'b0000));
    tbl.push_back(mk(LK, 7, 0, 'h55, 1, 0, 1, 'b0001));
    tbl.push_back(mk(WR, 255, 3, 'hABCDE));
    tbl.push_back(mk(LK, 255, 0, 'hABCDE, 1, 3, 0, 'b1000));
    tbl.push_back(mk(LK, 0, 0, 'hABCDE, 0, 0, 0, 'b0000));
    tbl.push_back(mk(WR, 0, 1, 'hABCDE));
    tbl.push_back(mk(LK, 0, 0, 'hABCDE, 1, 1, 0, 'b0010));
    tbl.push_back(mk(WR, 0, 0, 'h12345));
    tbl.push_back(mk(WR, 0, 2, 'h00001));
    tbl.push_back(mk(WR, 0, 3, 'h00002));
    tbl.push_back(mk(LK, 0, 0, 'h00002, 1, 3, 1, 'b1111));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    wait_idle("reset_sweep", 0, 256);
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n += int'(busy);
      if (i == 9) flush = 1'b1;
      if (i == 10) flush = 1'b0;
      if (i == 20) begin
        wr_en = 1'b1; wr_index = 8'd9; wr_way = 2'd0; wr_tag = 20'h99;
      end
      if (i == 21) wr_en = 1'b0;
    end
    wait_idle("flush_sweep", n, 266);
    @(posedge clk);
    #1;
    apply(mk(LK, 5, 0, 'h44, 0, 0, 0, 'b0000));
    apply(mk(LK, 7, 0, 'h55, 0, 0, 0, 'b0000));
    apply(mk(LK, 9, 0, 'h99, 0, 0, 0, 'b0000));
    apply(mk(LK, 255, 0, 'hABCDE, 0, 0, 0, 'b0000));
    apply(mk(LK, 0, 0, 'h00002, 0, 0, 0, 'b0000));
    apply(mk(WR, 5, 0, 'h11));
    repeat (2) @(posedge clk);
    #1;
    lk_valid = 1'b1; lk_index = 8'd5; lk_tag = 20'h11; reset = 1'b1;
    @(posedge clk);
    #1 lk_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    wait_idle("reset_mid_sweep", 0, 256);
    @(posedge clk);
    #1;
    apply(mk(LK, 5, 0, 'h11, 0, 0, 0, 'b0000));
    repeat (3) @(posedge clk);
    #1 chk("queue_drained_end", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
